// File: rtl/problem1_pkg.sv
// Shared constants for the median-of-three selector and its neighbours.
package problem1_pkg;

    localparam int P1_WIDTH = 8;
    localparam logic [P1_WIDTH-1:0] P1_RST_VAL = '0;

endpackage

// File: rtl/problem1_if.sv
// Datapath bundle for the median selector: three operands in, one median out.
interface problem1_if
    import problem1_pkg::*;
#(
    parameter int WIDTH = P1_WIDTH
);

    logic [WIDTH-1:0] i_p0;
    logic [WIDTH-1:0] i_p1;
    logic [WIDTH-1:0] i_p2;
    logic [WIDTH-1:0] o_p;

    modport master (
        output i_p0,
        output i_p1,
        output i_p2,
        input  o_p
    );

    modport slave (
        input  i_p0,
        input  i_p1,
        input  i_p2,
        output o_p
    );

endinterface

// File: rtl/problem1_cas.sv
// Combinational unsigned compare-and-swap cell: lo = min(a,b), hi = max(a,b).
module problem1_cas
    import problem1_pkg::*;
#(
    parameter int WIDTH = P1_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    always_comb begin
        lo = a;
        hi = b;
        if (a > b) begin
            lo = b;
            hi = a;
        end
    end

endmodule

// File: rtl/problem1.sv
// Registered median-of-three: three CAS cells feed a single output register.
module problem1
    import problem1_pkg::*;
#(
    parameter int WIDTH = P1_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    problem1_if.slave  bus
);

    logic [WIDTH-1:0] l1, h1, l2, med;
    logic [WIDTH-1:0] med_d, med_q;
    // Discarded halves of the network; the median only needs one side of each.
    logic [WIDTH-1:0] h2_unused, l3_unused;

    problem1_cas #(.WIDTH(WIDTH)) u_cas_ab (
        .a  (bus.i_p0),
        .b  (bus.i_p1),
        .lo (l1),
        .hi (h1)
    );

    problem1_cas #(.WIDTH(WIDTH)) u_cas_hc (
        .a  (h1),
        .b  (bus.i_p2),
        .lo (l2),
        .hi (h2_unused)
    );

    problem1_cas #(.WIDTH(WIDTH)) u_cas_med (
        .a  (l1),
        .b  (l2),
        .lo (l3_unused),
        .hi (med)
    );

    always_comb begin
        med_d = med;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            med_q <= WIDTH'(P1_RST_VAL);
        end else begin
            med_q <= med_d;
        end
    end

    assign bus.o_p = med_q;

endmodule

// File: tb/tb_problem1.sv
// Directed and random checks of the registered median-of-three selector.
module tb_problem1;
    import problem1_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    problem1_if #(.WIDTH(P1_WIDTH)) bus ();

    problem1 #(.WIDTH(P1_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive on the falling edge, check one rising edge later.
    task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] exp);
        @(negedge clk);
        bus.i_p0 = a;
        bus.i_p1 = b;
        bus.i_p2 = c;
        @(posedge clk);
        #1;
        check_eq(tag, bus.o_p, exp);
    endtask

    function automatic logic [7:0] ref_median(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
        logic [7:0] s [3];
        logic [7:0] t;
        s[0] = a;
        s[1] = b;
        s[2] = c;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t      = s[j];
                    s[j]   = s[j+1];
                    s[j+1] = t;
                end
            end
        end
        return s[1];
    endfunction

    logic [7:0] perm_a [6] = '{8'h11, 8'h11, 8'h74, 8'h74, 8'h81, 8'h81};
    logic [7:0] perm_b [6] = '{8'h74, 8'h81, 8'h11, 8'h81, 8'h11, 8'h74};
    logic [7:0] perm_c [6] = '{8'h81, 8'h74, 8'h81, 8'h11, 8'h74, 8'h11};

    initial begin
        logic [7:0] ra, rb, rc;
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.i_p0 = 8'h0F;
        bus.i_p1 = 8'h55;
        bus.i_p2 = 8'h88;

        // Reset asserted between edges must clear the output without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async", bus.o_p, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold", bus.o_p, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_release", bus.o_p, 8'h55);

        apply("all_zero", 8'h00, 8'h00, 8'h00, 8'h00);
        apply("dist_0f_55_88", 8'h0F, 8'h55, 8'h88, 8'h55);
        apply("dist_74_81_11", 8'h74, 8'h81, 8'h11, 8'h74);
        apply("b2b_a", 8'h01, 8'h02, 8'h03, 8'h02);
        apply("b2b_b", 8'hC0, 8'h30, 8'h90, 8'h90);

        for (int i = 0; i < 6; i++) begin
            apply($sformatf("perm%0d", i), perm_a[i], perm_b[i], perm_c[i], 8'h74);
        end

        apply("tie_10_10_f0", 8'h10, 8'h10, 8'hF0, 8'h10);
        apply("tie_f0_10_f0", 8'hF0, 8'h10, 8'hF0, 8'hF0);
        apply("tie_all_aa", 8'hAA, 8'hAA, 8'hAA, 8'hAA);
        apply("ext_00_ff_80", 8'h00, 8'hFF, 8'h80, 8'h80);
        apply("ext_ff_ff_00", 8'hFF, 8'hFF, 8'h00, 8'hFF);
        apply("ext_00_00_ff", 8'h00, 8'h00, 8'hFF, 8'h00);

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                #1;
                rst = 1'b1;
                #1;
                check_eq("rnd_rst_async", bus.o_p, 8'h00);
                @(posedge clk);
                #1;
                check_eq("rnd_rst_hold", bus.o_p, 8'h00);
                @(negedge clk);
                rst = 1'b0;
            end
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 8'($urandom_range(0, 255));
            apply("random", ra, rb, rc, ref_median(ra, rb, rc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
